// File: rtl/data_ram_responder_pkg.sv
// ----------------------------------------------------------------------------
// data_ram_responder_pkg
// Shared definitions for the data SRAM responder:
//   - dram_state_e : responder FSM encoding (DramIdle / DramBusy / DramDone)
//   - Stop/NoStop  : polarity of the stall request into the pipeline
//   - MAX_WAIT     : largest legal WAIT_CYCLES value (fits the 4-bit counter)
// ----------------------------------------------------------------------------
package data_ram_responder_pkg;

    typedef enum logic [1:0] {
        DramIdle = 2'd0,
        DramBusy = 2'd1,
        DramDone = 2'd2
    } dram_state_e;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam int MAX_WAIT = 15;

endpackage

// File: rtl/data_ram_responder_array.sv
// ----------------------------------------------------------------------------
// dram_array
// 2^ADDR_WIDTH x 32 word array with per-byte write enables and a registered
// read port. Contents are never reset; only the read register is.
// Ports:
//   clk     : rising-edge clock
//   resetn  : asynchronous active-low reset of the read register
//   en      : perform an access this edge
//   wen     : byte-lane write enables (0000 = read only)
//   clr     : access fell outside the address window; drop write, return 0
//   idx     : word index
//   wdata   : lane-aligned write data
//   q       : registered read data (pre-write word on writes)
// ----------------------------------------------------------------------------
module dram_array #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  en,
    input  logic [3:0]            wen,
    input  logic                  clr,
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic [31:0]           wdata,
    output logic [31:0]           q
);

    logic [31:0] mem [2**ADDR_WIDTH];

    // No reset here: a write that coincides with reset either lands on the
    // edge in full or not at all, so lanes are never partially updated.
    always_ff @(posedge clk) begin
        if (en && !clr) begin
            for (int i = 0; i < 4; i++) begin
                if (wen[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read-before-write: q samples the old word on the same edge as the write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q <= 32'h0;
        end else if (en) begin
            q <= clr ? 32'h0 : mem[idx];
        end
    end

endmodule

// File: rtl/data_ram_responder.sv
// ----------------------------------------------------------------------------
// data_ram_responder
// Responder for the EX-stage data SRAM interface. Performs byte-lane writes
// and word reads on an internal array, inserts WAIT_CYCLES wait states and
// requests a pipeline stall while an access is pending.
// Ports:
//   clk              : rising-edge clock
//   resetn           : asynchronous active-low reset
//   data_sram_en     : request valid
//   data_sram_wen    : byte-lane write enables, 0000 = read
//   data_sram_addr   : byte address ([1:0] ignored)
//   data_sram_wdata  : lane-aligned write data
//   data_sram_rdata  : registered read data, held until the next access
//   rdata_valid      : one-cycle pulse per completed access
//   addr_err         : registered with rdata_valid, 1 on window miss
//   stallreq_for_mem : Stop while EX must hold the request
//   dbg_state        : current FSM state
//
// Handshake: data_sram_en is the valid. EX keeps the request presented while
// stallreq_for_mem is Stop; the first edge with stallreq_for_mem at NoStop is
// the one on which EX advances. The response appears one cycle after that.
// ----------------------------------------------------------------------------
module data_ram_responder
    import data_ram_responder_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        rdata_valid,
    output logic        addr_err,
    output logic        stallreq_for_mem,
    output dram_state_e dbg_state
);

    localparam int TAG_LSB = ADDR_WIDTH + 2;

    dram_state_e state;
    logic [3:0]  cnt;

    // Latched request copy used for every delayed access.
    logic        lat_en;
    logic [3:0]  lat_wen;
    logic [31:2] lat_addr;
    logic [31:0] lat_wdata;

    // Access actually presented to the array this cycle.
    logic        acc_en;
    logic [3:0]  acc_wen;
    logic [31:2] acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_miss;

    logic        miss_q;
    logic [31:0] arr_q;
    logic [31:0] rdata_dly;

    logic        unused_addr_bits;
    assign unused_addr_bits = ^data_sram_addr[1:0];

    always_comb begin
        acc_en    = 1'b0;
        acc_wen   = lat_wen;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        case (state)
            // N=0 and N=1 both perform the access on the accepting edge, so
            // they must take the live request rather than the latch.
            DramIdle: begin
                if (data_sram_en && (WAIT_CYCLES <= 1)) begin
                    acc_en    = 1'b1;
                    acc_wen   = data_sram_wen;
                    acc_addr  = data_sram_addr[31:2];
                    acc_wdata = data_sram_wdata;
                end
            end
            // cnt==1 here means the decrement on this edge reaches zero.
            DramBusy: begin
                if (cnt == 4'd1) begin
                    acc_en = lat_en;
                end
            end
            default: ;
        endcase
    end

    assign acc_miss = (acc_addr[31:TAG_LSB] != BASE_ADDR[31:TAG_LSB]);

    // Stall depends only on state, en and WAIT_CYCLES (no address path).
    assign stallreq_for_mem =
        (resetn && ((state == DramBusy) ||
                    (state == DramIdle && data_sram_en && (WAIT_CYCLES != 0))))
        ? Stop : NoStop;

    dram_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk    (clk),
        .resetn (resetn),
        .en     (acc_en),
        .wen    (acc_wen),
        .clr    (acc_miss),
        .idx    (acc_addr[ADDR_WIDTH+1:2]),
        .wdata  (acc_wdata),
        .q      (arr_q)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= DramIdle;
            cnt         <= 4'd0;
            lat_en      <= 1'b0;
            lat_wen     <= 4'd0;
            lat_addr    <= '0;
            lat_wdata   <= 32'h0;
            miss_q      <= 1'b0;
            rdata_dly   <= 32'h0;
            rdata_valid <= 1'b0;
            addr_err    <= 1'b0;
        end else begin
            case (state)
                DramIdle: begin
                    if (data_sram_en && (WAIT_CYCLES != 0)) begin
                        lat_en    <= 1'b1;
                        lat_wen   <= data_sram_wen;
                        lat_addr  <= data_sram_addr[31:2];
                        lat_wdata <= data_sram_wdata;
                        cnt       <= 4'(WAIT_CYCLES - 1);
                        state     <= (WAIT_CYCLES == 1) ? DramDone : DramBusy;
                    end
                end
                DramBusy: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= DramDone;
                    end
                end
                // EX advances on this edge; the request it still shows is
                // already served, so it is not looked at.
                DramDone: begin
                    state <= DramIdle;
                end
                default: begin
                    state <= DramIdle;
                end
            endcase

            if (acc_en) begin
                miss_q <= acc_miss;
            end

            // Without wait states the array read register is the response.
            // With wait states the response is released on the DONE edge,
            // one cycle after the array produced it.
            if (WAIT_CYCLES == 0) begin
                rdata_valid <= acc_en;
                addr_err    <= acc_en && acc_miss;
            end else begin
                rdata_valid <= (state == DramDone);
                addr_err    <= (state == DramDone) && miss_q;
                if (state == DramDone) begin
                    rdata_dly <= arr_q;
                end
            end
        end
    end

    assign data_sram_rdata = (WAIT_CYCLES == 0) ? arr_q : rdata_dly;
    assign dbg_state       = state;

endmodule

// File: tb/tb_data_ram_responder.sv
// ----------------------------------------------------------------------------
// tb_data_ram_responder
// Directed bench for data_ram_responder. Five instances cover WAIT_CYCLES of
// 0, 1, 2, 3 and 5; they share wen/addr/wdata but each has its own en, so an
// instance only sees the requests aimed at it. Inputs change 1 ns after the
// rising edge, outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_data_ram_responder;
    import data_ram_responder_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        rst5_n;
    logic        en0, en1, en2, en3, en5;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic [31:0] rd0, rd1, rd2, rd3, rd5;
    logic        v0, v1, v2, v3, v5;
    logic        e0, e1, e2, e3, e5;
    logic        s0, s1, s2, s3, s5;
    dram_state_e st0, st1, st2, st3, st5;

    int tests_run;
    int tests_failed;

    data_ram_responder #(.WAIT_CYCLES(0)) u_n0 (
        .clk(clk), .resetn(rst_n), .data_sram_en(en0), .data_sram_wen(wen),
        .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rd0),
        .rdata_valid(v0), .addr_err(e0), .stallreq_for_mem(s0), .dbg_state(st0)
    );
    data_ram_responder #(.WAIT_CYCLES(1)) u_n1 (
        .clk(clk), .resetn(rst_n), .data_sram_en(en1), .data_sram_wen(wen),
        .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rd1),
        .rdata_valid(v1), .addr_err(e1), .stallreq_for_mem(s1), .dbg_state(st1)
    );
    data_ram_responder #(.WAIT_CYCLES(2)) u_n2 (
        .clk(clk), .resetn(rst_n), .data_sram_en(en2), .data_sram_wen(wen),
        .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rd2),
        .rdata_valid(v2), .addr_err(e2), .stallreq_for_mem(s2), .dbg_state(st2)
    );
    data_ram_responder #(.WAIT_CYCLES(3)) u_n3 (
        .clk(clk), .resetn(rst_n), .data_sram_en(en3), .data_sram_wen(wen),
        .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rd3),
        .rdata_valid(v3), .addr_err(e3), .stallreq_for_mem(s3), .dbg_state(st3)
    );
    data_ram_responder #(.WAIT_CYCLES(5)) u_n5 (
        .clk(clk), .resetn(rst_n & rst5_n), .data_sram_en(en5), .data_sram_wen(wen),
        .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rd5),
        .rdata_valid(v5), .addr_err(e5), .stallreq_for_mem(s5), .dbg_state(st5)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        wen   = w;
        addr  = a;
        wdata = d;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; rst5_n = 1'b1;
        en0 = 0; en1 = 0; en2 = 0; en3 = 0; en5 = 0;
        drive(4'h0, 32'h0, 32'h0);
        hold(3);
        @(negedge clk);
        tests_run++; if (rd0 !== 32'h0) begin tests_failed++; $display("FAIL reset_rd0 got=%h exp=0", rd0); end
        tests_run++; if (v0 !== 1'b0) begin tests_failed++; $display("FAIL reset_v0 got=%b exp=0", v0); end
        tests_run++; if (e3 !== 1'b0) begin tests_failed++; $display("FAIL reset_e3 got=%b exp=0", e3); end
        tests_run++; if (rd5 !== 32'h0) begin tests_failed++; $display("FAIL reset_rd5 got=%h exp=0", rd5); end
        tests_run++; if (st3 !== DramIdle) begin tests_failed++; $display("FAIL reset_st3 got=%0d exp=%0d", st3, DramIdle); end
        tests_run++; if (s2 !== 1'b0) begin tests_failed++; $display("FAIL reset_s2 got=%b exp=0", s2); end
        tick();
        rst_n = 1'b1;
        hold(2);
    endtask

    task automatic test_full_word();
        en0 = 1; drive(4'hF, 32'h10, 32'hDEADBEEF);
        @(negedge clk);
        tests_run++; if (s0 !== 1'b0) begin tests_failed++; $display("FAIL n0_stall_wr got=%b exp=0", s0); end
        tick();
        drive(4'h0, 32'h10, 32'h0);
        @(negedge clk);
        tests_run++; if (v0 !== 1'b1) begin tests_failed++; $display("FAIL n0_wr_valid got=%b exp=1", v0); end
        tests_run++; if (s0 !== 1'b0) begin tests_failed++; $display("FAIL n0_stall_rd got=%b exp=0", s0); end
        tick();
        en0 = 0;
        @(negedge clk);
        tests_run++; if (rd0 !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL n0_raw_rdata got=%h exp=deadbeef", rd0); end
        tests_run++; if (v0 !== 1'b1) begin tests_failed++; $display("FAIL n0_rd_valid got=%b exp=1", v0); end
        tests_run++; if (e0 !== 1'b0) begin tests_failed++; $display("FAIL n0_rd_err got=%b exp=0", e0); end
        tick();
        @(negedge clk);
        tests_run++; if (v0 !== 1'b0) begin tests_failed++; $display("FAIL n0_valid_pulse got=%b exp=0", v0); end
        tests_run++; if (rd0 !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL n0_rdata_hold got=%h exp=deadbeef", rd0); end
        tick();
    endtask

    task automatic test_byte_lanes();
        en0 = 1;
        drive(4'hF, 32'h20, 32'h11223344); tick();
        drive(4'h2, 32'h20, 32'h0000AA00); tick();
        drive(4'hC, 32'h20, 32'h55660000);
        @(negedge clk);
        tests_run++; if (rd0 !== 32'h11223344) begin tests_failed++; $display("FAIL lane_prewrite1 got=%h exp=11223344", rd0); end
        tick();
        drive(4'h0, 32'h20, 32'h0);
        @(negedge clk);
        tests_run++; if (rd0 !== 32'h1122AA44) begin tests_failed++; $display("FAIL lane_prewrite2 got=%h exp=1122aa44", rd0); end
        tick();
        drive(4'hF, 32'h24, 32'h0);
        @(negedge clk);
        tests_run++; if (rd0 !== 32'h5566AA44) begin tests_failed++; $display("FAIL lane_0010_1100 got=%h exp=5566aa44", rd0); end
        tick();
        drive(4'h1, 32'h24, 32'h000000A1); tick();
        drive(4'h4, 32'h24, 32'h00B20000); tick();
        drive(4'h8, 32'h24, 32'hC3000000); tick();
        drive(4'hF, 32'h28, 32'hFFFFFFFF);
        @(negedge clk);
        tests_run++; if (rd0 !== 32'h00B200A1) begin tests_failed++; $display("FAIL lane_0001_0100 got=%h exp=00b200a1", rd0); end
        tick();
        drive(4'h3, 32'h28, 32'h00001234); tick();
        drive(4'h0, 32'h24, 32'h0);
        @(negedge clk);
        tests_run++; if (rd0 !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL lane_prewrite3 got=%h exp=ffffffff", rd0); end
        tick();
        drive(4'h0, 32'h28, 32'h0);
        @(negedge clk);
        tests_run++; if (rd0 !== 32'hC3B200A1) begin tests_failed++; $display("FAIL lane_1000 got=%h exp=c3b200a1", rd0); end
        tick();
        en0 = 0;
        @(negedge clk);
        tests_run++; if (rd0 !== 32'hFFFF1234) begin tests_failed++; $display("FAIL lane_0011 got=%h exp=ffff1234", rd0); end
        tick();
    endtask

    task automatic test_miss();
        en0 = 1;
        drive(4'hF, 32'h0000_0000, 32'hCAFE0001); tick();
        drive(4'hF, 32'h0001_0000, 32'hBAD0BAD0);
        @(negedge clk);
        tests_run++; if (e0 !== 1'b0) begin tests_failed++; $display("FAIL miss_hit_err got=%b exp=0", e0); end
        tick();
        drive(4'h0, 32'h0000_0000, 32'h0);
        @(negedge clk);
        tests_run++; if (e0 !== 1'b1) begin tests_failed++; $display("FAIL miss_wr_err got=%b exp=1", e0); end
        tests_run++; if (rd0 !== 32'h0) begin tests_failed++; $display("FAIL miss_wr_rdata got=%h exp=0", rd0); end
        tick();
        drive(4'h0, 32'h0001_0000, 32'h0);
        @(negedge clk);
        tests_run++; if (rd0 !== 32'hCAFE0001) begin tests_failed++; $display("FAIL miss_no_write got=%h exp=cafe0001", rd0); end
        tick();
        en0 = 0;
        @(negedge clk);
        tests_run++; if (rd0 !== 32'h0) begin tests_failed++; $display("FAIL miss_rd_rdata got=%h exp=0", rd0); end
        tests_run++; if (e0 !== 1'b1 || v0 !== 1'b1) begin tests_failed++; $display("FAIL miss_rd_err got=%b/%b exp=1/1", e0, v0); end
        tick();
        @(negedge clk);
        tests_run++; if (e0 !== 1'b0) begin tests_failed++; $display("FAIL miss_err_pulse got=%b exp=0", e0); end
        tick();
    endtask

    task automatic test_wait1();
        en1 = 1; drive(4'hF, 32'h8, 32'h13579BDF);
        @(negedge clk);
        tests_run++; if (s1 !== 1'b1) begin tests_failed++; $display("FAIL n1_stall_t got=%b exp=1", s1); end
        tick();
        @(negedge clk);
        tests_run++; if (s1 !== 1'b0 || st1 !== DramDone) begin tests_failed++; $display("FAIL n1_done got=%b/%0d exp=0/%0d", s1, st1, DramDone); end
        tick();
        drive(4'h0, 32'h8, 32'h0);
        @(negedge clk);
        tests_run++; if (v1 !== 1'b1) begin tests_failed++; $display("FAIL n1_wr_valid got=%b exp=1", v1); end
        hold(2);
        en1 = 0;
        @(negedge clk);
        tests_run++; if (v1 !== 1'b1 || rd1 !== 32'h13579BDF) begin tests_failed++; $display("FAIL n1_read got=%b/%h exp=1/13579bdf", v1, rd1); end
        tick();
    endtask

    task automatic test_wait3_latch();
        en3 = 1; drive(4'hF, 32'h40, 32'h0BADF00D);
        hold(4);
        en3 = 0; drive(4'h0, 32'h0, 32'h0);
        hold(1);
        en3 = 1; drive(4'h0, 32'h40, 32'h0);
        @(negedge clk);
        tests_run++; if (s3 !== 1'b1 || v3 !== 1'b0) begin tests_failed++; $display("FAIL n3_t got=%b/%b exp=1/0", s3, v3); end
        tick();
        drive(4'hF, 32'h44, 32'hFFFF0000);
        @(negedge clk);
        tests_run++; if (s3 !== 1'b1 || st3 !== DramBusy) begin tests_failed++; $display("FAIL n3_t1 got=%b/%0d exp=1/%0d", s3, st3, DramBusy); end
        tick();
        drive(4'h0, 32'h48, 32'h0);
        @(negedge clk);
        tests_run++; if (s3 !== 1'b1) begin tests_failed++; $display("FAIL n3_t2 got=%b exp=1", s3); end
        tick();
        @(negedge clk);
        tests_run++; if (s3 !== 1'b0 || v3 !== 1'b0 || st3 !== DramDone) begin tests_failed++; $display("FAIL n3_t3 got=%b/%b/%0d exp=0/0/%0d", s3, v3, st3, DramDone); end
        tick();
        en3 = 0;
        @(negedge clk);
        tests_run++; if (v3 !== 1'b1 || rd3 !== 32'h0BADF00D) begin tests_failed++; $display("FAIL n3_t4 got=%b/%h exp=1/0badf00d", v3, rd3); end
        tick();
        @(negedge clk);
        tests_run++; if (v3 !== 1'b0 || rd3 !== 32'h0BADF00D) begin tests_failed++; $display("FAIL n3_t5 got=%b/%h exp=0/0badf00d", v3, rd3); end
        tick();
    endtask

    task automatic test_reset_busy();
        en5 = 1; drive(4'hF, 32'h80, 32'h5A5A5A5A);
        hold(6);
        en5 = 0; drive(4'h0, 32'h0, 32'h0);
        hold(1);
        en5 = 1; drive(4'h0, 32'h80, 32'h0);
        hold(2);
        rst5_n = 1'b0;
        #1;
        tests_run++; if (s5 !== 1'b0 || st5 !== DramIdle) begin tests_failed++; $display("FAIL rst_busy_fsm got=%b/%0d exp=0/%0d", s5, st5, DramIdle); end
        tests_run++; if (rd5 !== 32'h0 || v5 !== 1'b0 || e5 !== 1'b0) begin tests_failed++; $display("FAIL rst_busy_out got=%h/%b/%b exp=0/0/0", rd5, v5, e5); end
        en5 = 0;
        tick();
        rst5_n = 1'b1;
        tick();
        en5 = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++; if (s5 !== 1'b1) begin tests_failed++; $display("FAIL rst_fresh_stall%0d got=%b exp=1", i, s5); end
            tick();
        end
        @(negedge clk);
        tests_run++; if (s5 !== 1'b0 || v5 !== 1'b0) begin tests_failed++; $display("FAIL rst_fresh_done got=%b/%b exp=0/0", s5, v5); end
        tick();
        en5 = 0;
        @(negedge clk);
        tests_run++; if (v5 !== 1'b1 || rd5 !== 32'h5A5A5A5A) begin tests_failed++; $display("FAIL rst_fresh_read got=%b/%h exp=1/5a5a5a5a", v5, rd5); end
        tick();
    endtask

    task automatic test_back_to_back_reaccept();
        en2 = 1; drive(4'hF, 32'h100, 32'h77778888);
        @(negedge clk);
        tests_run++; if (s2 !== 1'b1) begin tests_failed++; $display("FAIL re_t got=%b exp=1", s2); end
        tick();
        @(negedge clk);
        tests_run++; if (s2 !== 1'b1 || st2 !== DramBusy) begin tests_failed++; $display("FAIL re_t1 got=%b/%0d exp=1/%0d", s2, st2, DramBusy); end
        tick();
        @(negedge clk);
        tests_run++; if (s2 !== 1'b0 || st2 !== DramDone) begin tests_failed++; $display("FAIL re_t2 got=%b/%0d exp=0/%0d", s2, st2, DramDone); end
        tick();
        @(negedge clk);
        tests_run++; if (s2 !== 1'b1 || v2 !== 1'b1) begin tests_failed++; $display("FAIL re_t3 got=%b/%b exp=1/1", s2, v2); end
        tick();
        en2 = 0;
        @(negedge clk);
        tests_run++; if (v2 !== 1'b0 || st2 !== DramBusy) begin tests_failed++; $display("FAIL re_t4 got=%b/%0d exp=0/%0d", v2, st2, DramBusy); end
        tick();
        @(negedge clk);
        tests_run++; if (v2 !== 1'b0 || st2 !== DramDone) begin tests_failed++; $display("FAIL re_t5 got=%b/%0d exp=0/%0d", v2, st2, DramDone); end
        tick();
        @(negedge clk);
        tests_run++; if (v2 !== 1'b1 || rd2 !== 32'h77778888) begin tests_failed++; $display("FAIL re_t6 got=%b/%h exp=1/77778888", v2, rd2); end
        tick();
        @(negedge clk);
        tests_run++; if (v2 !== 1'b0) begin tests_failed++; $display("FAIL re_t7 got=%b exp=0", v2); end
        en2 = 1; drive(4'h0, 32'h100, 32'h0);
        hold(3);
        en2 = 0;
        @(negedge clk);
        tests_run++; if (v2 !== 1'b1 || rd2 !== 32'h77778888) begin tests_failed++; $display("FAIL re_read got=%b/%h exp=1/77778888", v2, rd2); end
        tick();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_full_word();
        test_byte_lanes();
        test_miss();
        test_wait1();
        test_wait3_latch();
        test_reset_busy();
        test_back_to_back_reaccept();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/data_ram_responder.md
# data_ram_responder

Responder side of the data SRAM interface driven by the EX stage: accepts `data_sram_en/wen/addr/wdata` requests, performs byte-lane writes and word reads on an internal word array, and returns `data_sram_rdata` for the MEM stage. Configurable wait states let the bench and the SoC model slow memory. While an access is pending, the block raises a stall request into the pipeline stall controller.

## Interface
- `ADDR_WIDTH`, default 10: word-address bits; array depth is 2^ADDR_WIDTH words (4 KiB at default).
- `BASE_ADDR`, default 32'h0000_0000: window base; only bits [31:ADDR_WIDTH+2] are compared.
- `WAIT_CYCLES`, default 0: extra cycles per access, legal range 0..15.

Ports:
- `clk` in 1: single clock; everything is rising-edge.
- `resetn` in 1: asynchronous, active-low reset.
- `data_sram_en` in 1: request valid.
- `data_sram_wen` in 4: byte-lane write enables; 4'b0000 with `en` means read.
- `data_sram_addr` in 32: byte address; bits [1:0] are ignored for array indexing.
- `data_sram_wdata` in 32: write data, already lane-aligned.
- `data_sram_rdata` out 32: read data, registered.
- `rdata_valid` out 1: one-cycle pulse, in the cycle MEM consumes the response.
- `addr_err` out 1: registered alongside `rdata_valid`; 1 when the access fell outside the window.
- `stallreq_for_mem` out 1: `Stop` while the request must be held in EX.

## Operation
- Window hit: `addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]`.
- Word index: `addr[ADDR_WIDTH+1:2]`.
- Write: lane i updates with `wdata[8i+7:8i]` when `wen[i]`. Other lanes are unchanged. Every EX pattern must work: 0001, 0010, 0100, 1000, 0011, 1100, 1111.
- Read: returns the full word. Lane extraction and sign extension belong to MEM.
- A write also loads `data_sram_rdata` with the pre-write word (read-before-write).
- Miss: the write is dropped, `rdata` is 32'h0, `addr_err` is 1.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, `en`=1, WAIT_CYCLES=0: the access is performed on this edge; stay in IDLE; stall stays 0.
  - IDLE, `en`=1, WAIT_CYCLES=N>0: stall=1 combinationally this cycle; latch en/wen/addr/wdata; load cnt=N-1; go to BUSY, or straight to DONE when N=1, performing the access on that edge.
  - BUSY: stall=1; cnt decrements; at cnt==0 perform the access from the latched copy and go to DONE.
  - DONE: stall=0, so EX advances on this edge. The still-presented request is ignored. Go to IDLE unconditionally.
- The access always uses latched request fields; input changes during BUSY have no effect.
- No de-duplication after DONE. If another stall source holds EX, the same request is re-accepted. This is harmless: reads are idempotent and rewriting identical data is idempotent.
- Reset (`resetn`=0, any state, asynchronous):
  - FSM to IDLE, cnt=0.
  - `stallreq_for_mem`=0, `data_sram_rdata`=32'h0, `rdata_valid`=0, `addr_err`=0.
  - Array contents are not reset.
  - An interrupted write either fully commits or not at all; lanes are never partially written.

## Timing
- WAIT_CYCLES=0:
  - request in cycle t; `rdata`/`rdata_valid`/`addr_err` valid in cycle t+1;
  - no stall;
  - back-to-back requests every cycle.
- WAIT_CYCLES=N>0:
  - stall high in cycles t..t+N-1, low in t+N (DONE);
  - response valid in cycle t+N+1;
  - next request accepted no earlier than t+N+1.
- `rdata` holds its value until the next access. `rdata_valid` is high for exactly one cycle per access.
- Read-after-write to the same word in consecutive cycles (N=0) returns the new data.
- `stallreq_for_mem` is a combinational function of state, `en` and WAIT_CYCLES only; there is no path from `addr` or `wdata`.

## Structure
- `lib/defines.vh` gets the FSM state encodings (`DramIdle`, `DramBusy`, `DramDone`) and reuses the existing `Stop`/`NoStop`.
- One sub-module, `dram_array`: 2^ADDR_WIDTH×32 array, 4-bit byte-enable synchronous write, registered read. No reset on contents.
- FSM, counter, request latch and window decode live in `data_ram_responder`.

## Test plan
- N=0: write 32'hDEADBEEF with wen=1111 to 0x10, then read 0x10 next cycle → rdata=32'hDEADBEEF in the following cycle, `rdata_valid`=1, stall never high.
- N=0: over word 32'h11223344 at 0x20, write wen=0010 wdata=32'h0000AA00, then wen=1100 wdata=32'h55660000 → read gives 32'h5566AA44.
- N=3: read at t → stall high t..t+2, low t+3; `rdata_valid` at t+4 only. Changing `addr` during t+1..t+2 does not change the returned word.
- Miss: address 0x0001_0000 with defaults → write ignored (re-read of word 0 unchanged); read returns 0, `addr_err`=1 for one cycle.
- Reset mid-BUSY (N=5, resetn low at t+2) → all outputs 0 immediately, FSM IDLE. A fresh read after release completes normally with full N=5 timing.
- Re-accept: N=2 write held an extra cycle by an external stall after DONE → second write is accepted with the same data; array value is correct and two `rdata_valid` pulses appear.
